// File: rtl/mac_pkg.sv
// Shared definitions for the 2x2 MAC array slice: drain FSM encodings,
// datapath widths and accumulator word indices.
package mac_pkg;

    localparam int ACC_W     = 64;
    localparam int CNT_W     = 16;
    localparam int DRAIN_LAT = 3;
    localparam int N_WORDS   = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_FLUSH   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_SEND    = 3'd4,
        ST_CLEAR   = 3'd5
    } state_t;

    typedef logic [1:0] word_idx_t;

    localparam word_idx_t IDX_O00 = 2'd0;
    localparam word_idx_t IDX_O01 = 2'd1;
    localparam word_idx_t IDX_O10 = 2'd2;
    localparam word_idx_t IDX_O11 = 2'd3;

endpackage

// File: rtl/mac_snap_mux.sv
// Four-entry accumulator snapshot with a registered, index-selected output word.
// The first word is taken straight from the live inputs on the capture cycle.
module mac_snap_mux
    import mac_pkg::*;
#(
    parameter int ACC_W = mac_pkg::ACC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             capture,
    input  logic             load,
    input  logic [1:0]       sel,
    input  logic [ACC_W-1:0] o00,
    input  logic [ACC_W-1:0] o01,
    input  logic [ACC_W-1:0] o10,
    input  logic [ACC_W-1:0] o11,
    output logic [ACC_W-1:0] data
);

    logic [ACC_W-1:0] live [N_WORDS];
    logic [ACC_W-1:0] snap [N_WORDS];

    always_comb begin
        live[IDX_O00] = o00;
        live[IDX_O01] = o01;
        live[IDX_O10] = o10;
        live[IDX_O11] = o11;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: only four words, and a reset must leave no stale tile visible,
            // so the snapshot is reset as flops rather than built as a RAM.
            for (int i = 0; i < N_WORDS; i++) begin
                snap[i] <= '0;
            end
            data <= '0;
        end else if (capture) begin
            for (int i = 0; i < N_WORDS; i++) begin
                snap[i] <= live[i];
            end
            data <= live[sel];
        end else if (load) begin
            data <= snap[sel];
        end
    end

endmodule

// File: rtl/mac_result_drain.sv
// Read side of the 2x2 output-stationary MAC array: counts operand beats, waits out
// the array pipeline, snapshots the accumulators and streams them over valid/ready.
module mac_result_drain
    import mac_pkg::*;
#(
    parameter int ACC_W     = mac_pkg::ACC_W,
    parameter int CNT_W     = mac_pkg::CNT_W,
    parameter int DRAIN_LAT = mac_pkg::DRAIN_LAT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] k_len,
    input  logic             in_valid,
    input  logic [ACC_W-1:0] o00,
    input  logic [ACC_W-1:0] o01,
    input  logic [ACC_W-1:0] o10,
    input  logic [ACC_W-1:0] o11,
    output logic             acc_clr,
    output logic             busy,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [ACC_W-1:0] m_data,
    output logic [1:0]       m_idx,
    output logic             m_last,
    output logic             ovf
);

    localparam int LAT_W = $clog2(DRAIN_LAT + 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0] k_len_q, k_len_d;
    logic [CNT_W-1:0] beat_inc;
    logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
    word_idx_t        idx_q, idx_d;
    logic             ovf_d;
    logic             start_ok;
    logic             capture;
    logic             load;

    assign beat_inc = beat_cnt_q + CNT_W'(1);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave one unassigned and infer a latch.
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        k_len_d    = k_len_q;
        lat_cnt_d  = lat_cnt_q;
        idx_d      = idx_q;
        start_ok   = 1'b0;
        capture    = 1'b0;
        load       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && (k_len != '0)) begin
                    state_d    = ST_RUN;
                    beat_cnt_d = '0;
                    k_len_d    = k_len;
                    start_ok   = 1'b1;
                end
            end
            ST_RUN: begin
                if (in_valid) begin
                    beat_cnt_d = beat_inc;
                    if (beat_inc == k_len_q) begin
                        state_d   = ST_FLUSH;
                        lat_cnt_d = '0;
                    end
                end
            end
            ST_FLUSH: begin
                if (lat_cnt_q == LAT_W'(DRAIN_LAT - 1)) begin
                    state_d = ST_CAPTURE;
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                end
            end
            ST_CAPTURE: begin
                capture = 1'b1;
                idx_d   = IDX_O00;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (m_ready) begin
                    if (idx_q == IDX_O11) begin
                        state_d = ST_CLEAR;
                    end else begin
                        idx_d = idx_q + 2'd1;
                        load  = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A stray beat outside RUN wins over the clear from a same-cycle start.
        ovf_d = ovf;
        if (start_ok) begin
            ovf_d = 1'b0;
        end
        if (in_valid && (state_q != ST_RUN)) begin
            ovf_d = 1'b1;
        end
    end

    // Outputs are registered from the next-state decode so they line up with the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: non-blocking assignments for every flop so all registers
            // update from the same pre-edge values.
            state_q    <= ST_IDLE;
            beat_cnt_q <= '0;
            k_len_q    <= '0;
            lat_cnt_q  <= '0;
            idx_q      <= IDX_O00;
            acc_clr    <= 1'b0;
            busy       <= 1'b0;
            m_valid    <= 1'b0;
            m_idx      <= '0;
            m_last     <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            k_len_q    <= k_len_d;
            lat_cnt_q  <= lat_cnt_d;
            idx_q      <= idx_d;
            acc_clr    <= (state_d == ST_CLEAR);
            busy       <= (state_d != ST_IDLE);
            m_valid    <= (state_d == ST_SEND);
            m_idx      <= (state_d == ST_SEND) ? idx_d : '0;
            m_last     <= (state_d == ST_SEND) && (idx_d == IDX_O11);
            ovf        <= ovf_d;
        end
    end

    mac_snap_mux #(
        .ACC_W (ACC_W)
    ) u_snap (
        .clk     (clk),
        .rst     (rst),
        .capture (capture),
        .load    (load),
        .sel     (idx_d),
        .o00     (o00),
        .o01     (o01),
        .o10     (o10),
        .o11     (o11),
        .data    (m_data)
    );

endmodule
